booth_mult_seq: RTL
===================

# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier that replaces the fixed 8-bit signed multiplier datapath in the ALU. It accepts two WIDTH-bit operands on a start handshake and computes one Booth step per clock. It supports signed (two's complement) and unsigned modes and returns a full 2·WIDTH-bit product with a one-cycle done pulse. It sits behind the ALU operation decoder and is shared by the signed and unsigned multiply opcodes.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  system clock, 27 MHz on the board; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state and outputs immediately.
- start  input  1  request; sampled only in IDLE.
- mode_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- multiplicand  input  WIDTH  operand A; sampled with start.
- multiplier  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; product is valid.
- product  output  2·WIDTH  result register; holds its value until the next accepted start.

## Operation
- Internal width is W1 = WIDTH+1. In signed mode, operands are sign-extended to W1 bits; in unsigned mode they are zero-extended. This gives one uniform Booth datapath and a constant latency.
- The working register is {acc[W1-1:0], q[W1-1:0], q_m1}, 2·W1+1 bits. The extended multiplicand is held in a separate W1-bit register. A step counter runs 0..W1-1.
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE, start=1:
  - acc=0, q=extended multiplier, q_m1=0, counter=0.
  - Latch the extended multiplicand and mode.
  - Clear product to 0.
  - Go to CALC.
- IDLE, start=0: hold all state.
- CALC, each edge, one Booth step based on {q[0], q_m1}:
  - 01: acc += M.
  - 10: acc -= M.
  - 00 or 11: no add.
  - Then arithmetic right shift of {acc, q, q_m1} by 1, replicating the acc MSB.
  - Increment the counter.
- Leaving CALC: on the step where counter = W1-1, product ← low 2·WIDTH bits of the shifted {acc, q}, and the FSM goes to DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE.
- Add/sub arithmetic is W1 bits wide and wraps modulo 2^W1. The W1-bit extension guarantees the final result is exact: signed range −2^(2W−2)..2^(2W−2), unsigned max (2^W−1)².
- start while busy or done: ignored, not queued, no effect on the running operation.
- Operand or mode changes after acceptance: ignored, because all operands are latched.
- rst asserted at any time, including mid-CALC:
  - Abort immediately, no completion pulse.
  - FSM=IDLE; busy=0, done=0, product=0; working registers and counter cleared.

## Timing
- Reset values: busy=0, done=0, product=0, FSM=IDLE.
- Handshake:
  - start accepted at rising edge E0 (FSM in IDLE, start=1).
  - busy is high from after E0 through the edge E(W1).
  - The last Booth step occurs at E(W1), which also loads product.
  - done is high in the cycle between E(W1) and E(W1+1).
- Latency from acceptance to done: WIDTH+1 clocks, independent of data and mode.
- The earliest next accepted start is at E(W1+2), the first edge with FSM back in IDLE. Throughput is one product per WIDTH+3 cycles with back-to-back start.
- product is stable from E(W1) until the next accepted start clears it.
- done never coincides with busy.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then WIDTH=8, signed, A=5, B=3, start for one cycle -> busy for 9 cycles, done pulse 9 clocks after acceptance, product=16'h000F.
- Signed A=−128 (8'h80), B=−128 -> product=16'h4000. Then A=−128, B=127 -> product=16'hC080 (−16256).
- Unsigned A=8'hFF, B=8'hFF -> product=16'hFE01. Repeat with mode_signed=1 -> product=16'h0001.
- start held high continuously, operands changed mid-CALC -> result matches the operands latched at acceptance. The second operation is accepted exactly 11 clocks after the first.
- rst pulsed during step 4 of A=7, B=−2 -> busy, done and product go to 0 asynchronously. No done pulse occurs. A fresh start afterwards gives product=16'hFFF2.
- WIDTH=16 instance, random signed/unsigned sweep of ≥1000 vectors -> product equals the reference multiply. done occurs exactly 17 clocks after each acceptance.

Source files
------------

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult_seq
// Description : Sequential radix-2 Booth multiplier, signed/unsigned, one step
//               per clock, full 2*WIDTH-bit product with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int W1 = WIDTH + 1;
    localparam int CW = $clog2(W1);
    localparam logic [CW-1:0] C_LAST_STEP = CW'(W1 - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [W1-1:0]        r_acc;
    logic [W1-1:0]        r_q;
    logic                 r_q_m1;
    logic [W1-1:0]        r_mcand;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [W1-1:0]        w_ext_a;
    logic [W1-1:0]        w_ext_b;
    logic [W1-1:0]        w_acc_step;
    logic [2*W1:0]        w_shift;
    logic                 w_accept;
    logic                 w_last;

    // The extra top bit carries the sign (signed) or a zero (unsigned), so one
    // signed Booth datapath serves both modes; the mode needs no storage.
    assign w_ext_a  = {mode_signed & multiplicand[WIDTH-1], multiplicand};
    assign w_ext_b  = {mode_signed & multiplier[WIDTH-1], multiplier};
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_cnt == C_LAST_STEP);

    always_comb begin
        w_acc_step = r_acc;
        unique case ({r_q[0], r_q_m1})
            2'b01:   w_acc_step = r_acc + r_mcand;
            2'b10:   w_acc_step = r_acc - r_mcand;
            default: w_acc_step = r_acc;
        endcase
    end

    assign w_shift = {w_acc_step[W1-1], w_acc_step, r_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_q       <= '0;
            r_q_m1    <= 1'b0;
            r_mcand   <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_acc     <= '0;
            r_q       <= w_ext_b;
            r_q_m1    <= 1'b0;
            r_mcand   <= w_ext_a;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (r_state == S_CALC) begin
            r_acc  <= w_shift[2*W1:W1+1];
            r_q    <= w_shift[W1:1];
            r_q_m1 <= w_shift[0];
            r_cnt  <= r_cnt + CW'(1);
            // The W1-bit extension keeps the exact result inside the low 2*WIDTH bits.
            if (w_last) begin
                r_product <= w_shift[2*WIDTH:1];
            end
        end
    end

    assign busy    = (r_state == S_CALC);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

endmodule
`default_nettype wire
